// File: rtl/mem_responder_pkg.sv
// ============================================================================
// Module : mem_responder_pkg
// Brief  : Bus widths, responder FSM states, error codes and address check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_BUS  = 1'b1;

  // A request is bad if not word aligned or its word index lies beyond the RAM.
  function automatic logic addr_err(input logic [BUS_DW-1:0] addr, input int unsigned aw);
    logic [BUS_DW-3:0] word;
    word = addr[BUS_DW-1:2];
    return (addr[1:0] != 2'b00) || ((word >> aw) != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_sp_ram_be.sv
// ============================================================================
// Module : sp_ram_be
// Brief  : Single-port word RAM, synchronous read, per-byte write enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sp_ram_be
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [BUS_DW-1:0]  wdata_i,
  input  logic [BUS_BEW-1:0] be_i,
  output logic [BUS_DW-1:0]  rdata_o
);

  logic [BUS_DW-1:0] mem_q [2**ADDR_W];

  // Read data register only moves on a read, so it holds across idle cycles.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BUS_BEW; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module : mem_responder
// Brief  : One-at-a-time CPU bus responder backed by on-chip word RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [BUS_DW-1:0]  req_addr,
  input  logic [BUS_DW-1:0]  req_wdata,
  input  logic [BUS_BEW-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [BUS_DW-1:0]  rsp_rdata,
  output logic               rsp_err
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q;
  logic                 err_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [BUS_DW-1:0]    wdata_q;
  logic [BUS_BEW-1:0]   be_q;

  logic                 req_fire;
  logic                 rsp_fire;
  logic                 req_err;
  logic                 ram_en;
  logic [BUS_DW-1:0]    ram_rdata;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign req_err  = addr_err(req_addr, ADDR_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_fire) begin
        we_q    <= req_we;
        err_q   <= req_err ? ERR_BUS : ERR_NONE;
        addr_q  <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          if (req_err) begin
            state_d = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (rsp_fire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // No RAM traffic occurs in RESP, so the RAM output register is the held read data.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    ram_en    = (state_q == S_ACCESS);
    rsp_err   = rsp_valid && (err_q == ERR_BUS);
    rsp_rdata = (rsp_valid && (err_q == ERR_NONE) && !we_q) ? ram_rdata : '0;
  end

  sp_ram_be #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (we_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (ram_rdata)
  );

endmodule

`default_nettype wire
